bsg_fifo_1rw_large_front_end: RTL and testbench

//  Adapter placed directly in front of the single-ported large FIFO (bsg_fifo_1rw_large).

---
 rtl/bsg_fifo_1rw_large_front_end.sv | 159 +++++++++++++++
 tb/tb_bsg_fifo_1rw_large_front_end.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_fifo_1rw_large_front_end.sv
// bsg_fifo_1rw_large_front_end
//   Adapter that sits in front of a single-ported large FIFO (bsg_fifo_1rw_large).
//   It merges an independent ready/valid enqueue stream and a valid/yumi dequeue
//   stream onto the FIFO's single v/enq_not_deq command port. Reads and writes are
//   arbitrated round-robin. A 2-entry output buffer absorbs the FIFO's 1-cycle read
//   latency, so the consumer sees a plain valid/yumi stream.
//
// Parameters
//   width_p    data width in bits (>= 1)
//   verbose_p  1 = report each command issued to the FIFO (simulation only)
//
// Ports
//   clk_i, reset_n_i     clock, synchronous active-low reset
//   data_i/v_i/ready_o   enqueue side (transfer on v_i & ready_o)
//   data_o/v_o/yumi_i    dequeue side (yumi_i only while v_o)
//   fifo_data_o, fifo_v_o, fifo_enq_not_deq_o   command port to the FIFO
//   fifo_full_i, fifo_empty_i, fifo_data_i      status / read data from the FIFO
//
// Build option
//   BSG_FIFO_1RW_FE_BYPASS_EN: when the FIFO is empty and idle, the input register
//   moves straight into the output buffer without a FIFO command.

module bsg_fifo_1rw_large_front_end #(
  parameter int width_p   = 1,
  parameter int verbose_p = 0
) (
  input  logic               clk_i,
  input  logic               reset_n_i,

  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,

  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i,

  output logic [width_p-1:0] fifo_data_o,
  output logic               fifo_v_o,
  output logic               fifo_enq_not_deq_o,
  input  logic               fifo_full_i,
  input  logic               fifo_empty_i,
  input  logic [width_p-1:0] fifo_data_i
);

  localparam logic GRANT_RD = 1'b0;
  localparam logic GRANT_WR = 1'b1;

  // input register
  logic               in_v_q, in_v_d;
  logic [width_p-1:0] in_data_q, in_data_d;

  // arbiter / read pipeline
  logic               last_grant_q, last_grant_d;
  logic               rd_inflight_q;

  // output buffer
  logic [width_p-1:0] obuf_q [2];
  logic               obuf_head_q, obuf_head_d;
  logic               obuf_tail_q, obuf_tail_d;
  logic [1:0]         obuf_cnt_q, obuf_cnt_d;

  logic               wr_req, rd_req, wr_grant, rd_grant;
  logic               bypass, accept, push, pop;
  logic [width_p-1:0] push_data;
  logic [2:0]         obuf_occ;

`ifdef BSG_FIFO_1RW_FE_BYPASS_EN
  logic wr_last_q;

  // A write issued last cycle may not yet be visible as non-empty to this logic's
  // view of ordering, so it blocks the shortcut for one cycle.
  always_comb begin
    bypass = reset_n_i & in_v_q & fifo_empty_i & ~rd_inflight_q & ~wr_last_q
           & (obuf_cnt_q != 2'd2);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) wr_last_q <= 1'b0;
    else            wr_last_q <= wr_grant;
  end
`else
  always_comb begin
    bypass = 1'b0;
  end
`endif

  always_comb begin
    // Items already owed to the obuf (held + in flight) minus the one leaving now
    // must stay below 2 for a new read to be safe.
    obuf_occ = {1'b0, obuf_cnt_q} + {2'b00, rd_inflight_q};
    rd_req   = ~fifo_empty_i & (obuf_occ < (3'd2 + {2'b00, yumi_i}));
    wr_req   = in_v_q & ~fifo_full_i & ~bypass;

    wr_grant = reset_n_i & wr_req & (~rd_req | (last_grant_q == GRANT_RD));
    rd_grant = reset_n_i & rd_req & (~wr_req | (last_grant_q == GRANT_WR));

    ready_o  = reset_n_i & (~in_v_q | wr_grant | bypass);
    accept   = v_i & ready_o;

    fifo_v_o           = wr_grant | rd_grant;
    fifo_enq_not_deq_o = wr_grant;
    fifo_data_o        = in_data_q;

    in_v_d    = accept | (in_v_q & ~(wr_grant | bypass));
    in_data_d = accept ? data_i : in_data_q;

    last_grant_d = last_grant_q;
    if (wr_grant)      last_grant_d = GRANT_WR;
    else if (rd_grant) last_grant_d = GRANT_RD;

    // bypass and in-flight read data are mutually exclusive
    push      = rd_inflight_q | bypass;
    push_data = rd_inflight_q ? fifo_data_i : in_data_q;
    pop       = yumi_i;

    obuf_cnt_d  = obuf_cnt_q + {1'b0, push} - {1'b0, pop};
    obuf_head_d = pop  ? ~obuf_head_q : obuf_head_q;
    obuf_tail_d = push ? ~obuf_tail_q : obuf_tail_q;

    v_o    = (obuf_cnt_q != 2'd0);
    data_o = obuf_q[obuf_head_q];
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      in_v_q        <= 1'b0;
      in_data_q     <= '0;
      last_grant_q  <= GRANT_RD;
      rd_inflight_q <= 1'b0;
      obuf_q[0]     <= '0;
      obuf_q[1]     <= '0;
      obuf_head_q   <= 1'b0;
      obuf_tail_q   <= 1'b0;
      obuf_cnt_q    <= '0;
    end else begin
      in_v_q        <= in_v_d;
      in_data_q     <= in_data_d;
      last_grant_q  <= last_grant_d;
      rd_inflight_q <= rd_grant;
      if (push) obuf_q[obuf_tail_q] <= push_data;
      obuf_head_q   <= obuf_head_d;
      obuf_tail_q   <= obuf_tail_d;
      obuf_cnt_q    <= obuf_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(push && !pop && (obuf_cnt_q == 2'd2)))
        else $error("output buffer overflow");
      assert (!(yumi_i && !v_o))
        else $error("yumi_i asserted while v_o is low");
      if ((verbose_p != 0) && fifo_v_o)
        $info("fifo cmd: %s data=%h", wr_grant ? "enq" : "deq", in_data_q);
    end
  end

endmodule

// File: tb/tb_bsg_fifo_1rw_large_front_end.sv
module tb_bsg_fifo_1rw_large_front_end;

  localparam int W   = 8;
  localparam int ELS = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] data_i, data_o, fifo_data_o, fifo_data_i;
  logic         v_i, ready_o, v_o, yumi_i;
  logic         fifo_v_o, fifo_enq_not_deq_o, fifo_full_i, fifo_empty_i;

  int checks = 0;
  int errors = 0;
  int wr_ops = 0;
  int rd_ops = 0;

  logic [W-1:0] sb[$];
  logic [W-1:0] fq[$];

  // values sampled by drive()
  logic         s_acc, s_pop, s_ready, s_vo, s_fv, s_fen, s_full;
  logic [W-1:0] s_pd, s_fd;

  always #5 clk = ~clk;

  bsg_fifo_1rw_large_front_end #(.width_p(W), .verbose_p(0)) dut (
    .clk_i              (clk),
    .reset_n_i          (reset_n),
    .data_i             (data_i),
    .v_i                (v_i),
    .ready_o            (ready_o),
    .data_o             (data_o),
    .v_o                (v_o),
    .yumi_i             (yumi_i),
    .fifo_data_o        (fifo_data_o),
    .fifo_v_o           (fifo_v_o),
    .fifo_enq_not_deq_o (fifo_enq_not_deq_o),
    .fifo_full_i        (fifo_full_i),
    .fifo_empty_i       (fifo_empty_i),
    .fifo_data_i        (fifo_data_i)
  );

  // behavioural single-port FIFO, els = 8, 1-cycle read latency
  initial begin
    fifo_full_i  = 1'b0;
    fifo_empty_i = 1'b1;
    fifo_data_i  = '0;
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      fq.delete();
      fifo_full_i  <= 1'b0;
      fifo_empty_i <= 1'b1;
    end else begin
      if (fifo_v_o && fifo_enq_not_deq_o) begin
        wr_ops++;
        checks++;
        if (fq.size() >= ELS) begin
          errors++;
          $display("FAIL fifo_write_when_full: size %0d, limit %0d", fq.size(), ELS);
        end else fq.push_back(fifo_data_o);
      end else if (fifo_v_o) begin
        rd_ops++;
        checks++;
        if (fq.size() == 0) begin
          errors++;
          $display("FAIL fifo_read_when_empty: size 0, need >= 1");
        end else fifo_data_i <= fq.pop_front();
      end
      fifo_full_i  <= (fq.size() == ELS);
      fifo_empty_i <= (fq.size() == 0);
    end
  end

  // One cycle: drive at negedge, sample 1ns later, advance to posedge.
  task automatic drive(input logic v, input logic [W-1:0] d, input logic want_y);
    @(negedge clk);
    v_i    = v;
    data_i = d;
    yumi_i = want_y & v_o;
    #1;
    s_ready = ready_o;
    s_acc   = v & ready_o;
    s_pop   = yumi_i;
    s_pd    = data_o;
    s_vo    = v_o;
    s_fv    = fifo_v_o;
    s_fen   = fifo_enq_not_deq_o;
    s_fd    = fifo_data_o;
    s_full  = fifo_full_i;
    if (s_acc) sb.push_back(d);
    @(posedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    v_i     = 1'b1;
    data_i  = 8'h11;
    yumi_i  = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready_o); end
      checks++;
      if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v_o: got %b want 0", v_o); end
      checks++;
      if (fifo_v_o !== 1'b0) begin errors++; $display("FAIL reset_fifo_v: got %b want 0", fifo_v_o); end
    end
    @(negedge clk);
    v_i     = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", ready_o); end
    checks++;
    if (v_o !== 1'b0) begin errors++; $display("FAIL post_reset_v_o: got %b want 0", v_o); end
  endtask

  task automatic test_single;
    int w0, r0, lat, exp_lat, exp_ops;
    logic got;
`ifdef BSG_FIFO_1RW_FE_BYPASS_EN
    exp_lat = 2;
    exp_ops = 0;
`else
    exp_lat = 4;
    exp_ops = 1;
`endif
    w0 = wr_ops;
    r0 = rd_ops;
    drive(1'b1, 8'hA5, 1'b1);
    checks++;
    if (s_acc !== 1'b1) begin errors++; $display("FAIL single_accept: got %b want 1", s_acc); end
    got = 1'b0;
    lat = 0;
    for (int j = 1; j <= 20 && !got; j++) begin
      drive(1'b0, 8'h00, 1'b1);
      if (s_vo) begin
        got = 1'b1;
        lat = j;
        checks++;
        if (s_pd !== 8'hA5) begin errors++; $display("FAIL single_data: got %02h want a5", s_pd); end
      end
    end
    checks++;
    if (lat != exp_lat) begin errors++; $display("FAIL single_latency: got %0d want %0d", lat, exp_lat); end
    repeat (4) drive(1'b0, 8'h00, 1'b1);
    checks++;
    if (wr_ops - w0 != exp_ops) begin errors++; $display("FAIL single_writes: got %0d want %0d", wr_ops - w0, exp_ops); end
    checks++;
    if (rd_ops - r0 != exp_ops) begin errors++; $display("FAIL single_reads: got %0d want %0d", rd_ops - r0, exp_ops); end
  endtask

  task automatic test_fill;
    int idx, popcnt;
    idx = 0;
    for (int n = 0; n < 60; n++) begin
      drive(idx < 12, 8'(idx), 1'b0);
      if (s_acc) idx++;
    end
    checks++;
    if (idx != 11) begin errors++; $display("FAIL fill_accepted: got %0d want 11", idx); end
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b want 0", s_ready); end
    checks++;
    if (s_full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", s_full); end
    checks++;
    if (s_fd !== 8'd10) begin errors++; $display("FAIL fill_held_item: got %0d want 10", s_fd); end
    checks++;
    if (s_fv !== 1'b0) begin errors++; $display("FAIL fill_port_idle: got %b want 0", s_fv); end
    popcnt = 0;
    for (int n = 0; n < 120 && popcnt < 12; n++) begin
      drive(idx < 12, 8'(idx), 1'b1);
      if (s_acc) idx++;
      if (s_pop) begin
        checks++;
        if (s_pd !== 8'(popcnt)) begin errors++; $display("FAIL fill_drain_order: got %0d want %0d", s_pd, popcnt); end
        popcnt++;
      end
    end
    checks++;
    if (popcnt != 12) begin errors++; $display("FAIL fill_drain_count: got %0d want 12", popcnt); end
    repeat (3) drive(1'b0, 8'h00, 1'b1);
    checks++;
    if (s_vo !== 1'b0) begin errors++; $display("FAIL fill_no_duplicate: v_o got %b want 0", s_vo); end
  endtask

  task automatic test_contention;
    int n;
    logic [W-1:0] nxt, exp;
    logic prev;
    sb.delete();
    nxt = 8'h40;
    n = 0;
    while (nxt < 8'h46 && n < 40) begin
      drive(1'b1, nxt, 1'b0);
      if (s_acc) nxt++;
      n++;
    end
    checks++;
    if (nxt !== 8'h46) begin errors++; $display("FAIL contention_prefill: got %02h want 46", nxt); end
    repeat (10) drive(1'b0, 8'h00, 1'b0);
    prev = 1'b0;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, nxt, 1'b1);
      if (s_acc) nxt++;
      checks++;
      if (s_fv !== 1'b1) begin errors++; $display("FAIL contention_busy: cycle %0d fifo_v_o got %b want 1", i, s_fv); end
      if (i > 0) begin
        checks++;
        if (s_fen !== ~prev) begin errors++; $display("FAIL contention_alternate: cycle %0d enq got %b want %b", i, s_fen, ~prev); end
      end
      prev = s_fen;
      if (s_pop) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL contention_order: got %02h want nothing", s_pd); end
        else begin
          exp = sb.pop_front();
          if (s_pd !== exp) begin errors++; $display("FAIL contention_order: got %02h want %02h", s_pd, exp); end
        end
      end
    end
    for (int k = 0; k < 80 && sb.size() != 0; k++) begin
      drive(1'b0, 8'h00, 1'b1);
      if (s_pop) begin
        checks++;
        exp = sb.pop_front();
        if (s_pd !== exp) begin errors++; $display("FAIL contention_drain: got %02h want %02h", s_pd, exp); end
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL contention_left: got %0d want 0", sb.size()); end
  endtask

  task automatic test_backpressure;
    int sent, cyc;
    logic [W-1:0] exp;
    sb.delete();
    sent = 0;
    cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      drive(($urandom_range(0, 99) < 70) && (sent < 1000), 8'($urandom), $urandom_range(0, 99) < 30);
      if (s_acc) sent++;
      cyc++;
      checks++;
      if (dut.obuf_cnt_q > 2'd2) begin errors++; $display("FAIL bp_obuf_cnt: got %0d want <= 2", dut.obuf_cnt_q); end
      if (s_pop) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL bp_order: got %02h want nothing", s_pd); end
        else begin
          exp = sb.pop_front();
          if (s_pd !== exp) begin errors++; $display("FAIL bp_order: got %02h want %02h", s_pd, exp); end
        end
      end
    end
    checks++;
    if (sent != 1000) begin errors++; $display("FAIL bp_sent: got %0d want 1000", sent); end
    for (int k = 0; k < 200 && sb.size() != 0; k++) begin
      drive(1'b0, 8'h00, 1'b1);
      if (s_pop) begin
        checks++;
        exp = sb.pop_front();
        if (s_pd !== exp) begin errors++; $display("FAIL bp_drain: got %02h want %02h", s_pd, exp); end
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL bp_left: got %0d want 0", sb.size()); end
  endtask

  task automatic test_midreset;
    int idx;
    logic acc, got;
    idx = 0;
    for (int n = 0; n < 40 && idx < 5; n++) begin
      drive(1'b1, 8'(8'h60 + idx), 1'b0);
      if (s_acc) idx++;
    end
    checks++;
    if (idx != 5) begin errors++; $display("FAIL midreset_queued: got %0d want 5", idx); end
    repeat (3) drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    v_i     = 1'b0;
    yumi_i  = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (v_o !== 1'b0) begin errors++; $display("FAIL midreset_v_o: got %b want 0", v_o); end
    checks++;
    if (fifo_v_o !== 1'b0) begin errors++; $display("FAIL midreset_fifo_v: got %b want 0", fifo_v_o); end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    repeat (2) begin
      drive(1'b0, 8'h00, 1'b1);
      checks++;
      if (s_vo !== 1'b0) begin errors++; $display("FAIL midreset_stale: v_o got %b want 0", s_vo); end
    end
    acc = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      drive(!acc, 8'h3C, 1'b1);
      if (s_acc) acc = 1'b1;
      if (s_pop) begin
        got = 1'b1;
        checks++;
        if (s_pd !== 8'h3C) begin errors++; $display("FAIL midreset_first: got %02h want 3c", s_pd); end
      end
    end
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL midreset_timeout: got no output, want 3c"); end
  endtask

  initial begin
    reset_n = 1'b0;
    v_i     = 1'b0;
    data_i  = '0;
    yumi_i  = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_contention();
    test_backpressure();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
